uart_fifo_regs: RTL
===================

# uart_fifo_regs

Byte-wide UART register stage that sits directly behind the Wishbone adapter. It consumes that adapter's single-cycle write and read strobes, internal address, and 8-bit write data, and returns 8-bit read data. It also owns a 16-deep transmit FIFO, drained by the transmitter, and a 16-deep receive FIFO, filled by the receiver. It implements THR/RBR, IER, IIR/FCR, LSR and SCR, and drives a level interrupt.

## Interface
- ADDR_WIDTH, 3, register address width (matches `UART_ADDR_WIDTH`)
- FIFO_DEPTH, 16, entries per FIFO; must be a power of two
- PTR_W, 4, log2(FIFO_DEPTH)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- wb_rst_ni  in  1  reset, **synchronous, active-low**; one clock, reset sampled on the clk edge
- we_i  in  1  write strobe; each high cycle is exactly one write
- re_i  in  1  read strobe; each high cycle is exactly one read
- adr_i  in  ADDR_WIDTH  register address
- dat8_i  in  8  write data
- dat8_o  out  8  read data; combinational from adr_i and current state
- tf_data_o  out  8  TX FIFO head
- tf_valid_o  out  1  TX FIFO non-empty
- tf_ready_i  in  1  transmitter takes the head this cycle
- tf_busy_i  in  1  transmitter shift register is active
- rf_data_i  in  8  received byte
- rf_valid_i  in  1  push strobe, one cycle per byte; there is no backpressure
- int_o  out  1  registered interrupt request

## Operation
Register map:
- Address 0, write: push dat8_i into the TX FIFO.
- Address 0, read: dat8_o = RX head; pop the RX FIFO at the edge.
- Address 1: IER, read/write. Bit0 = RX-data-available enable, bit1 = THR-empty enable. Bits 7:2 read 0.
- Address 2, read: IIR = {4'b1100, code}. Code 4'b0100 = RX level at or above trigger (highest priority). Code 4'b0010 = TX FIFO empty. Code 4'b0001 = none. A code is reported only when its IER bit is set.
- Address 2, write: FCR. Bit1 clears the RX FIFO, bit2 clears the TX FIFO, bits 7:6 select the RX trigger level (00 = 1, 01 = 4, 10 = 8, 11 = 14). FCR is not readable.
- Address 5, read: LSR.
  - bit0 DR = RX FIFO non-empty
  - bit1 OE = overrun, sticky
  - bit5 THRE = TX FIFO empty
  - bit6 TEMT = THRE & ~tf_busy_i
  - other bits 0
  - an LSR read clears OE at the edge
- Address 7: SCR, read/write scratch.
- Other addresses: reads return 0; writes are ignored.

Reading an empty RX FIFO returns 0 and does not move the pointers.

FIFO rules (applied identically to both FIFOs):
- A push when full is dropped.
  - TX: silent.
  - RX: sets OE.
- Simultaneous push and pop when full: both take effect, count unchanged, OE not set.
- Simultaneous push and pop when empty: the push is accepted, the pop is ignored (count becomes 1).
- Pointers wrap modulo FIFO_DEPTH. Count is PTR_W+1 bits wide and ranges 0..16.
- FCR clear in the same cycle as a push or pop on that FIFO: the clear wins, the push is lost, and OE is not set.

tf_data_o is forced to 0 when the TX FIFO is empty.

int_o is registered one cycle from (IER[0] & rx_count ≥ trigger) | (IER[1] & THRE).

Reset values:
- FIFOs empty; IER = 0, SCR = 0, trigger = 1, OE = 0
- int_o = 0, tf_valid_o = 0, tf_data_o = 0
- dat8_o with adr_i = 5 is 8'h60; with adr_i = 2 it is 8'hC1

## Timing
- Reads: dat8_o is valid in the same cycle as re_i, because the adapter samples it at that edge. The pop or OE clear happens at that same edge, and the next read sees the new head.
- Writes: take effect at the edge where we_i = 1. A THR write shows tf_valid_o = 1 in the following cycle.
- TX pop: a transfer occurs on an edge where tf_valid_o & tf_ready_i. tf_ready_i is ignored when tf_valid_o = 0.
- RX push: becomes visible to DR and RBR in the cycle after rf_valid_i.
- int_o: lags the causing state by exactly one cycle.
- Reset mid-operation: wb_rst_ni low at an edge overrides all strobes in that cycle. Both FIFOs flush and every register returns to its reset value at that edge.
- we_i and re_i high together: both are processed. The read returns pre-write state.

## Structure
- Add to `uart_defines.v`:
  - register addresses (UART_REG_TR/RB = 0, IE = 1, II/FC = 2, LS = 5, SC = 7)
  - LSR bit indices
  - IIR codes
  - FCR field positions
  - trigger-level constants
- One sub-module, `uart_sync_fifo`, instantiated twice.
  - Parameters: WIDTH = 8, DEPTH, PTR_W.
  - Ports: push, pop, clear, data in/out, count, empty, full.
  - Uses the same clock and synchronous active-low reset as this block.
- Top level holds the decode, IER/SCR/OE/trigger registers, read mux and interrupt register.

## Test plan
- Reset, then read addresses 5, 2, 1, 7 -> 8'h60, 8'hC1, 8'h00, 8'h00; int_o = 0, tf_valid_o = 0.
- Write 8'hA5 and 8'h3C to THR with tf_ready_i = 0 -> LSR reads 8'h00 while tf_busy_i = 0. Then raise tf_ready_i -> tf_data_o shows A5, then 3C; THRE = 1 two cycles later.
- Push 17 RX bytes 0..16 -> LSR = 8'h63 (OE set); 16 RBR reads return 0..15. The LSR read clears OE, and the next LSR read is 8'h60.
- FCR = 8'h80 (trigger 8), IER = 1. Push 7 bytes -> int_o = 0, IIR = C1. 8th byte -> int_o = 1 one cycle later, IIR = C4. One RBR read -> int_o = 0.
- RX FIFO full, then rf_valid_i and RBR read in the same cycle -> OE stays 0, count stays 16. FCR = 8'h02 with rf_valid_i in the same cycle -> FIFO empty, OE = 0.
- Assert wb_rst_ni low for one edge in the middle of a TX burst (FIFO holding 5 bytes) -> next cycle tf_valid_o = 0 and all registers are at their reset values.

Source files
------------

// File: rtl/uart_fifo_regs_pkg.sv
// Register map, field positions and trigger levels shared by the UART
// register stage and its testbench-facing decode.
package uart_fifo_regs_pkg;

   localparam logic [2:0] UART_REG_TR = 3'd0;
   localparam logic [2:0] UART_REG_RB = 3'd0;
   localparam logic [2:0] UART_REG_IE = 3'd1;
   localparam logic [2:0] UART_REG_II = 3'd2;
   localparam logic [2:0] UART_REG_FC = 3'd2;
   localparam logic [2:0] UART_REG_LS = 3'd5;
   localparam logic [2:0] UART_REG_SC = 3'd7;

   localparam int unsigned LSR_DR   = 0;
   localparam int unsigned LSR_OE   = 1;
   localparam int unsigned LSR_THRE = 5;
   localparam int unsigned LSR_TEMT = 6;

   localparam logic [3:0] IIR_HIGH = 4'b1100;
   localparam logic [3:0] IIR_RDA  = 4'b0100;
   localparam logic [3:0] IIR_THRE = 4'b0010;
   localparam logic [3:0] IIR_NONE = 4'b0001;

   localparam int unsigned FCR_RX_CLR  = 1;
   localparam int unsigned FCR_TX_CLR  = 2;
   localparam int unsigned FCR_TRIG_LO = 6;
   localparam int unsigned FCR_TRIG_HI = 7;

   typedef enum logic [1:0] {
      TRIG_1  = 2'b00,
      TRIG_4  = 2'b01,
      TRIG_8  = 2'b10,
      TRIG_14 = 2'b11
   } trig_e;

   function automatic logic [7:0] trig_level(input trig_e t);
      case (t)
         TRIG_1:  return 8'd1;
         TRIG_4:  return 8'd4;
         TRIG_8:  return 8'd8;
         default: return 8'd14;
      endcase
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with clear; a push into a full FIFO is accepted only when
// a pop frees a slot at the same edge, and a pop of an empty FIFO is ignored.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic             clk,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic [PTR_W:0]   count_o,
   output logic             empty_o,
   output logic             full_o
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign empty_o = (r_count == '0);
   assign full_o  = (r_count == (PTR_W+1)'(DEPTH));
   assign count_o = r_count;
   assign data_o  = empty_o ? '0 : r_mem[r_rd_ptr];

   assign w_pop  = pop_i & ~empty_o;
   assign w_push = push_i & (~full_o | w_pop);

   always_ff @(posedge clk) begin
      if (!rst_ni || clear_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_ni && !clear_i && w_push) r_mem[r_wr_ptr] <= data_i;
   end

endmodule

// File: rtl/uart_fifo_regs.sv
// UART register stage: THR/RBR FIFOs, IER, IIR/FCR, LSR, SCR and a
// registered level interrupt, driven by single-cycle read/write strobes.
module uart_fifo_regs
   import uart_fifo_regs_pkg::*;
#(
   parameter int ADDR_WIDTH = 3,
   parameter int FIFO_DEPTH = 16,
   parameter int PTR_W      = 4
) (
   input  logic                  clk,
   input  logic                  wb_rst_ni,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] adr_i,
   input  logic [7:0]            dat8_i,
   output logic [7:0]            dat8_o,
   output logic [7:0]            tf_data_o,
   output logic                  tf_valid_o,
   input  logic                  tf_ready_i,
   input  logic                  tf_busy_i,
   input  logic [7:0]            rf_data_i,
   input  logic                  rf_valid_i,
   output logic                  int_o
);

   logic [1:0]     r_ier;
   logic [7:0]     r_scr;
   logic           r_oe;
   trig_e          r_trig;
   logic           r_int;

   logic           w_tx_push, w_tx_clr, w_tx_empty, w_tx_full;
   logic [PTR_W:0] w_tx_count;
   logic           w_rx_pop, w_rx_clr, w_rx_empty, w_rx_full;
   logic [PTR_W:0] w_rx_count;
   logic [7:0]     w_rx_data;
   logic           w_fcr_wr, w_lsr_rd, w_overrun, w_rx_trig, w_thre;
   logic [7:0]     w_lsr;
   logic [3:0]     w_iir_code;
   logic           w_tx_unused;

   assign w_fcr_wr  = we_i & (adr_i == ADDR_WIDTH'(UART_REG_FC));
   assign w_tx_push = we_i & (adr_i == ADDR_WIDTH'(UART_REG_TR));
   assign w_tx_clr  = w_fcr_wr & dat8_i[FCR_TX_CLR];
   assign w_rx_clr  = w_fcr_wr & dat8_i[FCR_RX_CLR];
   assign w_rx_pop  = re_i & (adr_i == ADDR_WIDTH'(UART_REG_RB));
   assign w_lsr_rd  = re_i & (adr_i == ADDR_WIDTH'(UART_REG_LS));

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_tx_fifo (
      .clk(clk), .rst_ni(wb_rst_ni),
      .push_i(w_tx_push), .pop_i(tf_ready_i), .clear_i(w_tx_clr),
      .data_i(dat8_i), .data_o(tf_data_o),
      .count_o(w_tx_count), .empty_o(w_tx_empty), .full_o(w_tx_full)
   );

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_rx_fifo (
      .clk(clk), .rst_ni(wb_rst_ni),
      .push_i(rf_valid_i), .pop_i(w_rx_pop), .clear_i(w_rx_clr),
      .data_i(rf_data_i), .data_o(w_rx_data),
      .count_o(w_rx_count), .empty_o(w_rx_empty), .full_o(w_rx_full)
   );

   assign w_tx_unused = &{1'b0, w_tx_count, w_tx_full};
   assign tf_valid_o  = ~w_tx_empty;
   assign w_thre      = w_tx_empty;
   assign w_rx_trig   = (w_rx_count >= (PTR_W+1)'(trig_level(r_trig)));
   // A full RX FIFO accepts a push only if a read frees a slot at the same edge.
   assign w_overrun   = rf_valid_i & w_rx_full & ~w_rx_pop & ~w_rx_clr;
   assign int_o       = r_int;

   always_comb begin
      w_lsr           = '0;
      w_lsr[LSR_DR]   = ~w_rx_empty;
      w_lsr[LSR_OE]   = r_oe;
      w_lsr[LSR_THRE] = w_thre;
      w_lsr[LSR_TEMT] = w_thre & ~tf_busy_i;
      w_iir_code      = IIR_NONE;
      if (r_ier[0] && w_rx_trig)   w_iir_code = IIR_RDA;
      else if (r_ier[1] && w_thre) w_iir_code = IIR_THRE;
   end

   always_comb begin
      dat8_o = '0;
      case (adr_i)
         ADDR_WIDTH'(UART_REG_RB): dat8_o = w_rx_data;
         ADDR_WIDTH'(UART_REG_IE): dat8_o = {6'b0, r_ier};
         ADDR_WIDTH'(UART_REG_II): dat8_o = {IIR_HIGH, w_iir_code};
         ADDR_WIDTH'(UART_REG_LS): dat8_o = w_lsr;
         ADDR_WIDTH'(UART_REG_SC): dat8_o = r_scr;
         default:                  dat8_o = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!wb_rst_ni) begin
         r_ier  <= '0;
         r_scr  <= '0;
         r_oe   <= 1'b0;
         r_trig <= TRIG_1;
         r_int  <= 1'b0;
      end else begin
         if (we_i && adr_i == ADDR_WIDTH'(UART_REG_IE)) r_ier <= dat8_i[1:0];
         if (we_i && adr_i == ADDR_WIDTH'(UART_REG_SC)) r_scr <= dat8_i;
         if (w_fcr_wr) r_trig <= trig_e'(dat8_i[FCR_TRIG_HI:FCR_TRIG_LO]);
         // A fresh overrun at the LSR-read edge stays visible for the next read.
         r_oe  <= (r_oe & ~w_lsr_rd) | w_overrun;
         r_int <= (r_ier[0] & w_rx_trig) | (r_ier[1] & w_thre);
      end
   end

endmodule
